// File: rtl/mandel_frame_sequencer.sv
// Frame sequencer: shadows view parameters at frame start, then walks the pixel grid in raster
// order toward the iteration engine over valid/ready, with first/last markers and frame accounting.
module mandel_frame_sequencer #(
    parameter int X_SIZE = 1280,
    parameter int Y_SIZE = 720,
    parameter int XW     = 11,
    parameter int YW     = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cfg_enable,
    input  logic          cfg_start,
    input  logic [31:0]   cfg_iter_max,
    input  logic [31:0]   cfg_zoom,
    input  logic [31:0]   cfg_x_offset,
    input  logic [31:0]   cfg_y_offset,
    output logic [XW-1:0] px_x,
    output logic [YW-1:0] px_y,
    output logic [31:0]   px_iter_max,
    output logic [31:0]   px_zoom,
    output logic [31:0]   px_x_offset,
    output logic [31:0]   px_y_offset,
    output logic          px_first,
    output logic          px_last_x,
    output logic          px_last_y,
    output logic          px_valid,
    input  logic          px_ready,
    output logic          busy,
    output logic          frame_done,
    output logic [15:0]   frame_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [XW-1:0] X_LAST = XW'(X_SIZE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(Y_SIZE - 1);

    state_t        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [31:0]   iter_max_q, iter_max_d;
    logic [31:0]   zoom_q, zoom_d;
    logic [31:0]   x_offset_q, x_offset_d;
    logic [31:0]   y_offset_q, y_offset_d;
    logic          frame_done_q, frame_done_d;
    logic          busy_q, busy_d;
    logic [15:0]   frame_count_q, frame_count_d;

    logic          in_run;

    assign in_run = (state_q == ST_RUN);

    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        iter_max_d    = iter_max_q;
        zoom_d        = zoom_q;
        x_offset_d    = x_offset_q;
        y_offset_d    = y_offset_q;
        frame_done_d  = 1'b0;
        frame_count_d = frame_count_q;

        case (state_q)
            ST_IDLE: begin
                if (cfg_start || cfg_enable) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                iter_max_d = cfg_iter_max;
                zoom_d     = cfg_zoom;
                x_offset_d = cfg_x_offset;
                y_offset_d = cfg_y_offset;
                x_d        = '0;
                y_d        = '0;
                state_d    = ST_RUN;
            end
            ST_RUN: begin
                if (px_ready) begin
                    if (x_q < X_LAST) begin
                        x_d = x_q + 1'b1;
                    end else begin
                        x_d = '0;
                        if (y_q < Y_LAST) begin
                            y_d = y_q + 1'b1;
                        end else begin
                            // Pulse is registered here so it lines up with the DONE cycle.
                            state_d      = ST_DONE;
                            frame_done_d = 1'b1;
                        end
                    end
                end
            end
            ST_DONE: begin
                frame_count_d = frame_count_q + 16'd1;
                state_d       = cfg_enable ? ST_LOAD : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            x_q           <= '0;
            y_q           <= '0;
            iter_max_q    <= '0;
            zoom_q        <= '0;
            x_offset_q    <= '0;
            y_offset_q    <= '0;
            frame_done_q  <= 1'b0;
            busy_q        <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            iter_max_q    <= iter_max_d;
            zoom_q        <= zoom_d;
            x_offset_q    <= x_offset_d;
            y_offset_q    <= y_offset_d;
            frame_done_q  <= frame_done_d;
            busy_q        <= busy_d;
            frame_count_q <= frame_count_d;
        end
    end

    // Markers decode registered state only, so px_ready never reaches an output combinationally.
    assign px_valid    = in_run;
    assign px_first    = in_run && (x_q == '0) && (y_q == '0);
    assign px_last_x   = in_run && (x_q == X_LAST);
    assign px_last_y   = in_run && (y_q == Y_LAST);
    assign px_x        = x_q;
    assign px_y        = y_q;
    assign px_iter_max = iter_max_q;
    assign px_zoom     = zoom_q;
    assign px_x_offset = x_offset_q;
    assign px_y_offset = y_offset_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_mandel_frame_sequencer.sv
// Bench for mandel_frame_sequencer on a 4x3 grid: a pixel-index reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_mandel_frame_sequencer;

    localparam int XS   = 4;
    localparam int YS   = 3;
    localparam int NPIX = XS * YS;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_enable = 1'b0;
    logic        cfg_start = 1'b0;
    logic [31:0] cfg_iter_max = 32'd25;
    logic [31:0] cfg_zoom = 32'h0000_1234;
    logic [31:0] cfg_x_offset = 32'hFFFF_0010;
    logic [31:0] cfg_y_offset = 32'h0000_0020;
    logic        px_ready = 1'b1;

    logic [1:0]  px_x;
    logic [1:0]  px_y;
    logic [31:0] px_iter_max, px_zoom, px_x_offset, px_y_offset;
    logic        px_first, px_last_x, px_last_y, px_valid, busy, frame_done;
    logic [15:0] frame_count;

    mandel_frame_sequencer #(.X_SIZE(XS), .Y_SIZE(YS), .XW(2), .YW(2)) dut (
        .clk(clk), .reset(reset),
        .cfg_enable(cfg_enable), .cfg_start(cfg_start),
        .cfg_iter_max(cfg_iter_max), .cfg_zoom(cfg_zoom),
        .cfg_x_offset(cfg_x_offset), .cfg_y_offset(cfg_y_offset),
        .px_x(px_x), .px_y(px_y),
        .px_iter_max(px_iter_max), .px_zoom(px_zoom),
        .px_x_offset(px_x_offset), .px_y_offset(px_y_offset),
        .px_first(px_first), .px_last_x(px_last_x), .px_last_y(px_last_y),
        .px_valid(px_valid), .px_ready(px_ready),
        .busy(busy), .frame_done(frame_done), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a phase (0 idle, 1 load, 2 run, 3 done) plus a linear pixel index.
    int          m_phase = 0;
    int          m_p = 0;
    int          m_count = 0;
    logic [31:0] m_iter = '0, m_zoom = '0, m_xo = '0, m_yo = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_phase = 0; m_p = 0; m_count = 0;
            m_iter = '0; m_zoom = '0; m_xo = '0; m_yo = '0;
        end else begin
            case (m_phase)
                0: if (cfg_start || cfg_enable) m_phase = 1;
                1: begin
                    m_iter = cfg_iter_max; m_zoom = cfg_zoom;
                    m_xo = cfg_x_offset; m_yo = cfg_y_offset;
                    m_p = 0; m_phase = 2;
                end
                2: if (px_ready) begin
                    if (m_p == NPIX - 1) m_phase = 3;
                    else m_p = m_p + 1;
                end
                default: begin
                    m_count = (m_count + 1) % 65536;
                    m_phase = cfg_enable ? 1 : 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("mdl_valid", 32'(px_valid), 32'(m_phase == 2));
            chk("mdl_busy", 32'(busy), 32'(m_phase != 0));
            chk("mdl_done", 32'(frame_done), 32'(m_phase == 3));
            chk("mdl_count", 32'(frame_count), 32'(m_count));
            chk("mdl_iter", px_iter_max, m_iter);
            chk("mdl_zoom", px_zoom, m_zoom);
            chk("mdl_xoff", px_x_offset, m_xo);
            chk("mdl_yoff", px_y_offset, m_yo);
            if (m_phase == 2) begin
                chk("mdl_x", 32'(px_x), 32'(m_p % XS));
                chk("mdl_y", 32'(px_y), 32'(m_p / XS));
                chk("mdl_first", 32'(px_first), 32'(m_p == 0));
                chk("mdl_last_x", 32'(px_last_x), 32'((m_p % XS) == XS - 1));
                chk("mdl_last_y", 32'(px_last_y), 32'((m_p / XS) == YS - 1));
            end else begin
                chk("mdl_flags_idle", 32'({px_first, px_last_x, px_last_y}), 32'd0);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        // Reset values
        step(2);
        chk("rst_valid", 32'(px_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_count", 32'(frame_count), 32'd0);
        chk("rst_iter", px_iter_max, 32'd0);
        reset = 1'b0;
        mon_en = 1'b1;

        // Single frame, no backpressure
        cfg_start = 1'b1;
        step(1);
        cfg_start = 1'b0;
        chk("f1_load_valid", 32'(px_valid), 32'd0);
        chk("f1_load_busy", 32'(busy), 32'd1);
        step(1);
        chk("f1_first", 32'(px_first), 32'd1);
        chk("f1_x0", 32'(px_x), 32'd0);
        chk("f1_iter", px_iter_max, 32'd25);
        step(3);
        chk("f1_x3", 32'(px_x), 32'd3);
        chk("f1_lastx", 32'(px_last_x), 32'd1);
        chk("f1_first_off", 32'(px_first), 32'd0);
        step(8);
        chk("f1_end_xy", 32'({px_x, px_y}), 32'({2'd3, 2'd2}));
        chk("f1_end_lasty", 32'(px_last_y), 32'd1);
        step(1);
        chk("f1_done", 32'(frame_done), 32'd1);
        chk("f1_done_busy", 32'(busy), 32'd1);
        chk("f1_done_count", 32'(frame_count), 32'd0);
        step(1);
        chk("f1_idle_busy", 32'(busy), 32'd0);
        chk("f1_idle_count", 32'(frame_count), 32'd1);

        // Backpressure at (2,1) plus a config change mid-frame
        cfg_start = 1'b1;
        step(1);
        cfg_start = 1'b0;
        step(4);
        cfg_iter_max = 32'd100;
        step(3);
        chk("bp_at_x", 32'(px_x), 32'd2);
        chk("bp_at_y", 32'(px_y), 32'd1);
        px_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_hold_xy", 32'({px_x, px_y}), 32'({2'd2, 2'd1}));
            chk("bp_hold_valid", 32'(px_valid), 32'd1);
            step(1);
        end
        chk("bp_last_hold", 32'({px_x, px_y}), 32'({2'd2, 2'd1}));
        chk("bp_shadow", px_iter_max, 32'd25);
        px_ready = 1'b1;
        step(1);
        chk("bp_resume", 32'({px_x, px_y}), 32'({2'd3, 2'd1}));
        step(4);
        chk("bp_end", 32'({px_x, px_y}), 32'({2'd3, 2'd2}));
        step(1);
        chk("bp_done", 32'(frame_done), 32'd1);
        step(1);
        chk("bp_count", 32'(frame_count), 32'd2);

        // Next frame picks up the new parameter
        cfg_start = 1'b1;
        step(1);
        cfg_start = 1'b0;
        step(1);
        chk("sh_iter_new", px_iter_max, 32'd100);
        step(12);
        chk("sh_done", 32'(frame_done), 32'd1);
        step(1);
        chk("sh_count", 32'(frame_count), 32'd3);

        // Continuous mode from a fresh reset
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        cfg_enable = 1'b1;
        step(1);
        chk("cm_load_valid", 32'(px_valid), 32'd0);
        step(1);
        for (int f = 1; f <= 3; f++) begin
            chk("cm_first", 32'(px_first), 32'd1);
            if (f == 3) begin
                step(5);
                cfg_enable = 1'b0;
                step(6);
            end else begin
                step(11);
            end
            chk("cm_last", 32'({px_last_x, px_last_y}), 32'd3);
            step(1);
            chk("cm_done", 32'(frame_done), 32'd1);
            chk("cm_gap1_valid", 32'(px_valid), 32'd0);
            chk("cm_done_count", 32'(frame_count), 32'(f - 1));
            step(1);
            chk("cm_after_count", 32'(frame_count), 32'(f));
            chk("cm_gap2_valid", 32'(px_valid), 32'd0);
            if (f < 3) begin
                chk("cm_gap2_busy", 32'(busy), 32'd1);
                step(1);
                chk("cm_run_again", 32'(px_valid), 32'd1);
            end else begin
                chk("cm_stop_busy", 32'(busy), 32'd0);
            end
        end

        // Reset mid-frame, restart, and a start pulse ignored during RUN
        cfg_start = 1'b1;
        step(1);
        cfg_start = 1'b0;
        step(1);
        step(5);
        chk("rs_at", 32'({px_x, px_y}), 32'({2'd1, 2'd1}));
        reset = 1'b1;
        step(1);
        chk("rs_valid", 32'(px_valid), 32'd0);
        chk("rs_busy", 32'(busy), 32'd0);
        chk("rs_count", 32'(frame_count), 32'd0);
        chk("rs_iter", px_iter_max, 32'd0);
        reset = 1'b0;
        cfg_start = 1'b1;
        step(1);
        cfg_start = 1'b0;
        step(1);
        chk("rs_restart_first", 32'(px_first), 32'd1);
        chk("rs_restart_xy", 32'({px_x, px_y}), 32'd0);
        step(3);
        cfg_start = 1'b1;
        step(1);
        cfg_start = 1'b0;
        step(7);
        chk("rs_end", 32'({px_x, px_y}), 32'({2'd3, 2'd2}));
        step(1);
        chk("rs_done", 32'(frame_done), 32'd1);
        step(5);
        chk("rs_no_second_valid", 32'(px_valid), 32'd0);
        chk("rs_no_second_busy", 32'(busy), 32'd0);
        chk("rs_final_count", 32'(frame_count), 32'd1);

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
